// File: rtl/encoder_4_2_stream_pkg.sv
// Shared types and the priority-encode function for the 4-to-2 stream encoder.
//   IN_W / CODE_W  : request-vector and index widths
//   enc_entry_t    : one queued result {code, zero, multi}
//   fill_state_t   : output-queue occupancy, encoded as the entry count
//   prio_encode()  : combinational priority encoder with zero/multi flags
package enc_pkg;

  localparam int IN_W   = 4;
  localparam int CODE_W = 2;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              zero;
    logic              multi;
  } enc_entry_t;

  // State value equals the number of valid entries, so it doubles as the count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fill_state_t;

  // Scans bits from index 0 upward. With prio_high every set bit overwrites
  // the code, leaving the highest one. Otherwise only the first set bit is
  // kept, which is the lowest one.
  function automatic enc_entry_t prio_encode(input logic [IN_W-1:0] vec,
                                             input bit              prio_high);
    enc_entry_t  e;
    int unsigned ones;
    e    = '0;
    ones = 0;
    for (int i = 0; i < IN_W; i++) begin
      if (vec[i]) begin
        ones = ones + 1;
        if (prio_high || ones == 1) e.code = CODE_W'(i);
      end
    end
    e.zero  = (ones == 0);
    e.multi = (ones > 1);
    return e;
  endfunction

endpackage

// File: rtl/encoder_4_2_stream_if.sv
// Handshake bundle for encoder_4_2_stream.
//   in_valid/in_ready/code_in                 : request side
//   out_valid/out_ready/code_out/out_zero/out_multi : result side
//   slave  : the encoder
//   master : the environment, which drives requests and consumes results
interface encoder_4_2_stream_if;
  import enc_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   code_in;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] code_out;
  logic              out_zero;
  logic              out_multi;

  modport slave (
    input  in_valid, code_in, out_ready,
    output in_ready, out_valid, code_out, out_zero, out_multi
  );

  modport master (
    output in_valid, code_in, out_ready,
    input  in_ready, out_valid, code_out, out_zero, out_multi
  );

endinterface

// File: rtl/encoder_4_2_stream_fifo2_reg.sv
// Two-entry register FIFO of enc_entry_t, built as a shift pair.
//   clk, rst_n : clock and async active-low reset
//   push_i     : write din_i. The caller must not push when count_o == 2.
//   pop_i      : drop the head. The caller must not pop when count_o == 0.
//   din_i      : entry to write
//   head_o     : slot 0. It keeps the last popped value while empty.
//   count_o    : number of valid entries (0..2)
module fifo2_reg
  import enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  enc_entry_t din_i,
  output enc_entry_t head_o,
  output logic [1:0] count_o
);

  fill_state_t state_q, state_d;
  enc_entry_t  slot0_q, slot0_d;
  enc_entry_t  slot1_q, slot1_d;

  // Slot 0 is always the head. A pop never clears it, so the outputs hold
  // the last delivered result while the queue is empty.
  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    unique case (state_q)
      EMPTY: begin
        if (push_i) begin
          slot0_d = din_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push_i && pop_i) begin
          slot0_d = din_i;
        end else if (push_i) begin
          slot1_d = din_i;
          state_d = FULL;
        end else if (pop_i) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop_i) begin
          slot0_d = slot1_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      slot0_q <= '0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
    end
  end

  // The second slot is never observable until it has been written, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    slot1_q <= slot1_d;
  end

  assign head_o  = slot0_q;
  assign count_o = state_q;

endmodule

// File: rtl/encoder_4_2_stream.sv
// Streaming 4-to-2 priority encoder with a 2-entry output queue and a
// saturating error counter for non-one-hot inputs.
//   PRIO_HIGH : 1 = highest set bit wins, 0 = lowest set bit wins
//   ERR_CNT_W : width of err_count
//   clk, rst_n : clock and async active-low reset
//   clr_err    : synchronous clear of err_count. It wins over an increment.
//   bus        : request/result handshake (slave side)
//   err_count  : accepted zero-hot or multi-hot beats, saturating at all-ones
module encoder_4_2_stream
  import enc_pkg::*;
#(
  parameter bit PRIO_HIGH = 1'b1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_err,
  encoder_4_2_stream_if.slave  bus,
  output logic [ERR_CNT_W-1:0] err_count
);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  enc_entry_t            enc;
  enc_entry_t            head;
  logic [1:0]            count;
  logic                  push;
  logic                  pop;
  logic [ERR_CNT_W-1:0]  err_q, err_d;

  assign enc = prio_encode(bus.code_in, PRIO_HIGH);

  // in_ready depends only on registered occupancy. A full queue refuses a
  // beat even when a pop happens in the same cycle, which keeps out_ready
  // off the in_ready path.
  assign bus.in_ready  = (count < 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  fifo2_reg u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (enc),
    .head_o  (head),
    .count_o (count)
  );

  assign bus.code_out  = head.code;
  assign bus.out_zero  = head.zero;
  assign bus.out_multi = head.multi;

  always_comb begin
    err_d = err_q;
    if (clr_err)
      err_d = '0;
    else if (push && (enc.zero || enc.multi))
      err_d = sat_inc(err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_count = err_q;

endmodule

// File: tb/tb_encoder_4_2_stream.sv
// Randomized + directed bench for encoder_4_2_stream. Two instances share one
// stimulus: A (PRIO_HIGH=1, ERR_CNT_W=8) and B (PRIO_HIGH=0, ERR_CNT_W=2).
// The reference keeps the raw request vectors in a queue and derives the
// expected outputs arithmetically.
module tb_encoder_4_2_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] err_a;
  logic [1:0] err_b;

  encoder_4_2_stream_if ifa ();
  encoder_4_2_stream_if ifb ();

  encoder_4_2_stream #(.PRIO_HIGH(1'b1), .ERR_CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr_err(clr_err), .bus(ifa), .err_count(err_a));
  encoder_4_2_stream #(.PRIO_HIGH(1'b0), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr_err(clr_err), .bus(ifb), .err_count(err_b));

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [3:0] mq[$];
  logic [3:0] last_raw = 4'd0;
  bit         has_last = 1'b0;
  int unsigned m_err_a = 0;
  int unsigned m_err_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Index of the highest set bit: how many halvings until the value is 0, minus one.
  function automatic int ref_high(input int unsigned v);
    int h = -1;
    while (v > 0) begin
      v = v / 2;
      h++;
    end
    return h;
  endfunction

  function automatic logic [1:0] ref_code(input logic [3:0] v, input bit high);
    int unsigned x;
    x = v;
    if (x == 0) return 2'd0;
    if (high) return 2'(ref_high(x));
    return 2'(ref_high(x & ((~x) + 1)));
  endfunction

  task automatic check_all();
    bit         hv;
    logic [3:0] h;
    hv = (mq.size() > 0) || has_last;
    h  = (mq.size() > 0) ? mq[0] : last_raw;
    check("a_out_valid", 32'(ifa.out_valid), 32'(mq.size() > 0));
    check("a_in_ready",  32'(ifa.in_ready),  32'(mq.size() < 2));
    check("a_code",      32'(ifa.code_out),  hv ? 32'(ref_code(h, 1'b1)) : 32'd0);
    check("a_zero",      32'(ifa.out_zero),  32'(hv && h == 0));
    check("a_multi",     32'(ifa.out_multi), 32'(hv && $countones(h) > 1));
    check("a_err",       32'(err_a),         m_err_a);
    check("b_out_valid", 32'(ifb.out_valid), 32'(mq.size() > 0));
    check("b_in_ready",  32'(ifb.in_ready),  32'(mq.size() < 2));
    check("b_code",      32'(ifb.code_out),  hv ? 32'(ref_code(h, 1'b0)) : 32'd0);
    check("b_zero",      32'(ifb.out_zero),  32'(hv && h == 0));
    check("b_multi",     32'(ifb.out_multi), 32'(hv && $countones(h) > 1));
    check("b_err",       32'(err_b),         m_err_b);
  endtask

  task automatic step(input logic v, input logic [3:0] c, input logic ordy, input logic clr);
    bit acc, pp, badbeat;
    ifa.in_valid = v; ifa.code_in = c; ifa.out_ready = ordy;
    ifb.in_valid = v; ifb.code_in = c; ifb.out_ready = ordy;
    clr_err = clr;
    acc     = v && (mq.size() < 2);
    pp      = ordy && (mq.size() > 0);
    badbeat = acc && (c == 0 || $countones(c) > 1);
    @(posedge clk);
    if (pp) begin
      last_raw = mq.pop_front();
      has_last = 1'b1;
    end
    if (acc) mq.push_back(c);
    if (clr) begin
      m_err_a = 0;
      m_err_b = 0;
    end else if (badbeat) begin
      if (m_err_a < 255) m_err_a++;
      if (m_err_b < 3)   m_err_b++;
    end
    #1;
    check_all();
  endtask

  initial begin
    ifa.in_valid = 0; ifa.code_in = 0; ifa.out_ready = 0;
    ifb.in_valid = 0; ifb.code_in = 0; ifb.out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();

    step(1, 4'b0100, 1, 0);
    check("first_code", 32'(ifa.code_out), 32'd2);
    step(1, 4'b1010, 1, 0);
    check("multi_hi", 32'(ifa.code_out), 32'd3);
    check("multi_lo", 32'(ifb.code_out), 32'd1);
    check("multi_err", 32'(err_a), 32'd1);
    step(1, 4'b0000, 1, 0);
    step(1, 4'b0011, 1, 1);
    check("clr_wins", 32'(err_a), 32'd0);
    step(0, 4'b0000, 1, 0);

    step(1, 4'b0001, 0, 0);
    step(1, 4'b0010, 0, 0);
    check("full_ready", 32'(ifa.in_ready), 32'd0);
    step(1, 4'b1000, 0, 0);
    step(1, 4'b1000, 1, 0);
    step(1, 4'b1000, 1, 0);
    check("third_code", 32'(ifa.code_out), 32'd3);
    step(0, 4'b0000, 1, 0);

    repeat (4) step(1, 4'b0000, 1, 0);
    check("sat_b", 32'(err_b), 32'd3);
    step(1, 4'b0110, 1, 0);
    check("sat_hold", 32'(err_b), 32'd3);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0));

    repeat (3) step(1, 4'b0101, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(ifa.out_valid), 32'd0);
    check("rst_ready", 32'(ifa.in_ready), 32'd1);
    check("rst_err",   32'(err_a), 32'd0);
    mq.delete();
    has_last = 1'b0;
    last_raw = 4'd0;
    m_err_a  = 0;
    m_err_b  = 0;
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
